// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
//   RV32I instruction-decode stage sitting directly in front of the register
//   file. It drives the regfile read selects from the incoming instruction,
//   bypasses writeback data that lands in the same cycle, decodes the
//   immediate, detects load-use hazards and registers the decoded instruction
//   into the ID/EX pipeline register under a valid/ready handshake. A flush
//   discards both the ID/EX contents and the incoming instruction.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   instr_i, pc_i       instruction and its PC from fetch
//   valid_i / ready_o   upstream handshake
//   rs1_sel_o/rs2_sel_o combinational regfile read selects
//   rs1_val_i/rs2_val_i regfile read data
//   wb_we_i/wb_rd_i/wb_val_i  writeback port (same as regfile write)
//   ex_load_i/ex_rd_i   load currently in EX and its destination
//   flush_i             branch redirect: drop ID/EX and incoming instruction
//   valid_o / ready_i   downstream handshake
//   pc_o, instr_o, rs1_val_o, rs2_val_o, imm_o, rd_o  registered ID/EX payload
// -----------------------------------------------------------------------------
module id_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [4:0]      rs1_sel_o,
    output logic [4:0]      rs2_sel_o,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_val_i,
    input  logic            ex_load_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] rs1_val_o,
    output logic [XLEN-1:0] rs2_val_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rd_o
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Operand select with writeback bypass. The regfile only commits a write
    // on the next edge, so a same-cycle write to the source must be forwarded.
    // x0 is hard-wired to zero regardless of what the regfile or WB presents.
    function automatic logic [31:0] f_bypass(
        input logic [4:0]  sel,
        input logic [31:0] rf_val,
        input logic        we,
        input logic [4:0]  rd,
        input logic [31:0] wval
    );
        logic [31:0] v;
        if (sel == 5'd0) begin
            v = 32'd0;
        end else if (we && (rd == sel)) begin
            v = wval;
        end else begin
            v = rf_val;
        end
        return v;
    endfunction

    // Immediate extraction by major opcode; unknown opcodes give zero.
    function automatic logic [31:0] f_imm(input logic [31:0] ins);
        logic [31:0] v;
        case (ins[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                v = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:
                v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:
                v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                v = {ins[31:12], 12'd0};
            OP_JAL:
                v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:
                v = 32'd0;
        endcase
        return v;
    endfunction

    logic [4:0]      w_rs1_sel;
    logic [4:0]      w_rs2_sel;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm;
    logic            w_hazard;
    logic            w_ready;
    logic            w_accept;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rd;

    assign w_rs1_sel = instr_i[19:15];
    assign w_rs2_sel = instr_i[24:20];

    // Decode: bypassed operands, immediate, load-use hazard and handshake.
    // The hazard compares both rs fields for every format (conservative).
    always_comb begin
        w_rs1_val = f_bypass(w_rs1_sel, rs1_val_i, wb_we_i, wb_rd_i, wb_val_i);
        w_rs2_val = f_bypass(w_rs2_sel, rs2_val_i, wb_we_i, wb_rd_i, wb_val_i);
        w_imm     = f_imm(instr_i);
        w_hazard  = valid_i & ex_load_i & (ex_rd_i != 5'd0)
                  & ((ex_rd_i == w_rs1_sel) | (ex_rd_i == w_rs2_sel));
        // A flush always consumes the incoming instruction.
        w_ready   = flush_i | (~w_hazard & (~r_valid | ready_i));
        w_accept  = valid_i & w_ready & ~flush_i;
    end

    // ID/EX pipeline register: reset > flush > accept > drain > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_rd      <= 5'd0;
        end else if (flush_i) begin
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_pc      <= pc_i;
            r_instr   <= instr_i;
            r_rs1_val <= w_rs1_val;
            r_rs2_val <= w_rs2_val;
            r_imm     <= w_imm;
            r_rd      <= instr_i[11:7];
        end else if (ready_i) begin
            // EX consumed the entry and nothing replaces it (bubble).
            r_valid   <= 1'b0;
        end else begin
            r_valid   <= r_valid;
        end
    end

    assign ready_o   = w_ready;
    assign rs1_sel_o = w_rs1_sel;
    assign rs2_sel_o = w_rs2_sel;
    assign valid_o   = r_valid;
    assign pc_o      = r_pc;
    assign instr_o   = r_instr;
    assign rs1_val_o = r_rs1_val;
    assign rs2_val_o = r_rs2_val;
    assign imm_o     = r_imm;
    assign rd_o      = r_rd;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
//   Self-checking bench for id_stage. Expected ID/EX payloads are pushed into
//   a scoreboard queue when an instruction is accepted by the bench's model of
//   the handshake and compared against the DUT registers each cycle.
// -----------------------------------------------------------------------------
module tb_id_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  rs1_sel_o;
    logic [4:0]  rs2_sel_o;
    logic [31:0] rs1_val_i;
    logic [31:0] rs2_val_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_val_i;
    logic        ex_load_i;
    logic [4:0]  ex_rd_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [31:0] rs1_val_o;
    logic [31:0] rs2_val_o;
    logic [31:0] imm_o;
    logic [4:0]  rd_o;

    id_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr_i   (instr_i),
        .pc_i      (pc_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .rs1_sel_o (rs1_sel_o),
        .rs2_sel_o (rs2_sel_o),
        .rs1_val_i (rs1_val_i),
        .rs2_val_i (rs2_val_i),
        .wb_we_i   (wb_we_i),
        .wb_rd_i   (wb_rd_i),
        .wb_val_i  (wb_val_i),
        .ex_load_i (ex_load_i),
        .ex_rd_i   (ex_rd_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .pc_o      (pc_o),
        .instr_o   (instr_o),
        .rs1_val_o (rs1_val_o),
        .rs2_val_o (rs2_val_o),
        .imm_o     (imm_o),
        .rd_o      (rd_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic        m_valid;
    logic        m_zero;
    logic [31:0] cur_imm;
    logic [31:0] regs [32];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic v, input logic [31:0] imm);
        instr_i   = ins;
        pc_i      = pc;
        valid_i   = v;
        cur_imm   = imm;
        rs1_val_i = regs[ins[19:15]];
        rs2_val_i = regs[ins[24:20]];
    endtask

    // One clock cycle: check combinational outputs, update model at the edge,
    // then compare registered outputs against the scoreboard head.
    task automatic cycle();
        exp_t e;
        logic hz, rdy, acc;
        #1;
        hz  = valid_i && ex_load_i && (ex_rd_i != 5'd0)
              && ((ex_rd_i == instr_i[19:15]) || (ex_rd_i == instr_i[24:20]));
        rdy = flush_i || (!hz && (!m_valid || ready_i));
        acc = valid_i && rdy && !flush_i;
        check("ready_o",   {31'd0, ready_o},   {31'd0, rdy});
        check("rs1_sel_o", {27'd0, rs1_sel_o}, {27'd0, instr_i[19:15]});
        check("rs2_sel_o", {27'd0, rs2_sel_o}, {27'd0, instr_i[24:20]});
        e.pc    = pc_i;
        e.instr = instr_i;
        e.imm   = cur_imm;
        e.rd    = instr_i[11:7];
        e.rs1   = (instr_i[19:15] == 5'd0) ? 32'd0 :
                  (wb_we_i && wb_rd_i == instr_i[19:15]) ? wb_val_i : rs1_val_i;
        e.rs2   = (instr_i[24:20] == 5'd0) ? 32'd0 :
                  (wb_we_i && wb_rd_i == instr_i[24:20]) ? wb_val_i : rs2_val_i;
        @(posedge clk);
        if (rst) begin
            sb.delete(); m_valid = 1'b0; m_zero = 1'b1;
        end else if (flush_i) begin
            sb.delete(); m_valid = 1'b0; m_zero = 1'b0;
        end else if (acc) begin
            if (sb.size() > 0) void'(sb.pop_front());
            sb.push_back(e); m_valid = 1'b1; m_zero = 1'b0;
        end else if (ready_i) begin
            if (sb.size() > 0) void'(sb.pop_front());
            m_valid = 1'b0;
        end
        #1;
        check("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
        if (m_valid && sb.size() > 0) begin
            check("pc_o",      pc_o,            sb[0].pc);
            check("instr_o",   instr_o,         sb[0].instr);
            check("rs1_val_o", rs1_val_o,       sb[0].rs1);
            check("rs2_val_o", rs2_val_o,       sb[0].rs2);
            check("imm_o",     imm_o,           sb[0].imm);
            check("rd_o",      {27'd0, rd_o},   {27'd0, sb[0].rd});
        end else if (m_zero) begin
            check("rst_pc_o",    pc_o,          32'd0);
            check("rst_instr_o", instr_o,       32'd0);
            check("rst_rs1_o",   rs1_val_o,     32'd0);
            check("rst_rs2_o",   rs2_val_o,     32'd0);
            check("rst_imm_o",   imm_o,         32'd0);
            check("rst_rd_o",    {27'd0, rd_o}, 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
        regs[0] = 32'hDEAD_BEEF;   // x0 must read as zero whatever the RF returns
        regs[2] = 32'h0000_0011;
        m_valid = 1'b0; m_zero = 1'b0;
        rst = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
        wb_we_i = 1'b0; wb_rd_i = 5'd0; wb_val_i = 32'd0;
        ex_load_i = 1'b0; ex_rd_i = 5'd0;
        drive(32'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        cycle(); cycle();
        rst = 1'b0;

        // addi x1,x0,5
        drive(32'h0050_0093, 32'h0000_0100, 1'b1, 32'h0000_0005);
        cycle();
        // add x3,x2,x2 with same-cycle writeback of x2
        wb_we_i = 1'b1; wb_rd_i = 5'd2; wb_val_i = 32'h0000_00AA;
        drive(32'h0021_01B3, 32'h0000_0104, 1'b1, 32'd0);
        cycle();
        // add x7,x0,x0 with a writeback to x0
        wb_rd_i = 5'd0; wb_val_i = 32'h0000_00FF;
        drive(32'h0000_03B3, 32'h0000_0108, 1'b1, 32'd0);
        cycle();
        wb_we_i = 1'b0;

        // load-use: add x6,x5,x1 behind a load to x5
        ex_load_i = 1'b1; ex_rd_i = 5'd5;
        drive(32'h0012_8333, 32'h0000_010C, 1'b1, 32'd0);
        cycle();
        ex_load_i = 1'b0;
        cycle();

        // sw, then stall 3 cycles holding beq at the input
        drive(32'hFE11_2E23, 32'h0000_0110, 1'b1, 32'hFFFF_FFFC);
        cycle();
        ready_i = 1'b0;
        drive(32'hFE00_0EE3, 32'h0000_0114, 1'b1, 32'hFFFF_FFFC);
        cycle(); cycle(); cycle();
        ready_i = 1'b1;
        cycle();
        drive(32'h1234_50B7, 32'h0000_0118, 1'b1, 32'h1234_5000);
        cycle();
        drive(32'hFFDF_F0EF, 32'h0000_011C, 1'b1, 32'hFFFF_FFFC);
        cycle();

        // flush while stalled with a new instruction offered
        ready_i = 1'b0; flush_i = 1'b1;
        drive(32'h0050_0093, 32'h0000_0200, 1'b1, 32'h0000_0005);
        cycle();
        flush_i = 1'b0; ready_i = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 32'd0);
        cycle();

        // reset during a stall
        drive(32'h0050_0093, 32'h0000_0300, 1'b1, 32'h0000_0005);
        cycle();
        ready_i = 1'b0;
        drive(32'h1234_50B7, 32'h0000_0304, 1'b1, 32'h1234_5000);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; ready_i = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 32'd0);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
